fifo_uart_tx: RTL



---
 rtl/fifo_uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FWFT FIFO reader that serialises each popped word as a UART frame
module fifo_uart_tx #(
    parameter int    CLKS_PER_BIT = 868,
    parameter int    WIDTH        = 8,
    parameter string PARITY       = "NONE",
    parameter int    STOP_BITS    = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    input  logic             i_FifoEmpty,
    input  logic [WIDTH-1:0] i_FifoData,
    output logic             o_FifoRdEn,
    output logic             o_Tx,
    output logic             o_Busy,
    output logic             o_Done
);

    localparam int               CLK_W      = $clog2(CLKS_PER_BIT);
    localparam int               BIT_W      = $clog2(WIDTH);
    localparam logic [CLK_W-1:0] CLK_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_PENULT = CLK_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 2);
    localparam bit               HAS_PARITY = (PARITY != "NONE");
    localparam bit               ODD_PARITY = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CLK_W-1:0] r_clk_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_stop_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_par;

    logic w_clk_last;
    logic w_stop_end;
    logic w_launch;

    assign w_clk_last = (r_clk_cnt == CLK_LAST);
    assign w_stop_end = (r_state == S_STOP) && w_clk_last && (r_stop_cnt == STOP_LAST);
    // A new frame may start from idle or in the very last cycle of the previous stop bit
    assign w_launch   = i_Enable && !i_FifoEmpty && ((r_state == S_IDLE) || w_stop_end);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            o_FifoRdEn <= 1'b0;
            o_Tx       <= 1'b1;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
        end else begin
            o_FifoRdEn <= 1'b0;
            o_Done     <= 1'b0;
            if (w_launch) begin
                r_shift    <= i_FifoData;
                r_par      <= (^i_FifoData) ^ ODD_PARITY;
                r_clk_cnt  <= '0;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                o_FifoRdEn <= 1'b1;
                o_Tx       <= 1'b0;
                o_Busy     <= 1'b1;
                r_state    <= S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clk_cnt <= '0;
                        o_Tx      <= 1'b1;
                        o_Busy    <= 1'b0;
                    end
                    S_START: begin
                        if (w_clk_last) begin
                            r_clk_cnt <= '0;
                            r_bit_cnt <= '0;
                            o_Tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_state   <= S_DATA;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_clk_last) begin
                            r_clk_cnt <= '0;
                            if (r_bit_cnt == BIT_LAST) begin
                                if (HAS_PARITY) begin
                                    o_Tx    <= r_par;
                                    r_state <= S_PARITY;
                                end else begin
                                    o_Tx       <= 1'b1;
                                    r_stop_cnt <= 1'b0;
                                    r_state    <= S_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                o_Tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (w_clk_last) begin
                            r_clk_cnt  <= '0;
                            r_stop_cnt <= 1'b0;
                            o_Tx       <= 1'b1;
                            r_state    <= S_STOP;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_clk_last) begin
                            r_clk_cnt <= '0;
                            if (r_stop_cnt != STOP_LAST) begin
                                r_stop_cnt <= 1'b1;
                            end else begin
                                o_Busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                            // Registered pulse lands on the final cycle of the last stop bit
                            if ((r_stop_cnt == STOP_LAST) && (r_clk_cnt == CLK_PENULT)) begin
                                o_Done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        o_Tx    <= 1'b1;
                        o_Busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
